// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry {pc, inst} queue.
// The queue head drives ID directly; a redirect flushes the queue and reloads the PC.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4),
  parameter int                CNT_W    = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [ADDR_W-1:0]  pc;
  logic               started;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  // Redirect kills both push and pop so the flushed head is never issued.
  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o & id_ready_i & ~redirect_i;
  assign rom_ce_o   = started & ~redirect_i & ((count < FULL) | pop);
  assign push       = rom_ce_o;
  assign rom_addr_o = pc;
  assign count_o    = count;

  assign head      = mem[rd_ptr];
  assign id_pc_o   = id_valid_o ? head.pc   : '0;
  assign id_inst_o = id_valid_o ? head.inst : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      started <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_i) begin
        pc     <= redirect_pc_i;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          pc     <= pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset or cleared on flush; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc, inst: rom_data_i};
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: fill/stall, full-queue pop+push, redirects,
// random back-pressure ordering, and asynchronous reset mid-stall.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr + 32'h1000;

  if_fetch_queue dut (
    .clk(clk), .rst(rst),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .rom_data_i(rom_data),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Leaves time at posedge+1, ready for new inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, ".valid"}, id_valid, 1);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".inst"}, id_inst, pc + 32'h1000);
    chk({tag, ".count"}, count, cnt);
  endtask

  initial begin
    int fetches, issues;
    logic [31:0] exp_fetch, exp_issue;

    rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst.addr", rom_addr, 0);
    chk("rst.ce", rom_ce, 0);
    chk("rst.count", count, 0);
    chk("rst.valid", id_valid, 0);
    chk("rst.pc", id_pc, 0);
    chk("rst.inst", id_inst, 0);

    // Release; started rises on the next edge, first fetch the cycle after.
    rst = 1'b0;
    #1 chk("rel.ce_low", rom_ce, 0);
    step(); #1;
    chk("c0.ce", rom_ce, 1);
    chk("c0.addr", rom_addr, 0);
    chk("c0.valid", id_valid, 0);
    step(); #1;
    chk_head("c1", 32'h0, 1);
    chk("c1.addr", rom_addr, 32'h4);
    step(); #1; chk_head("c2", 32'h4, 1);
    step();
    id_ready = 1'b0; #1;
    chk_head("c3", 32'h8, 1);
    chk("c3.ce", rom_ce, 1);

    // Stall: queue fills to 4 holding 8,C,10,14; fetch freezes at 0x18.
    step(); #1; chk_head("c4", 32'h8, 2); chk("c4.addr", rom_addr, 32'h10);
    step(); #1; chk_head("c5", 32'h8, 3); chk("c5.addr", rom_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk_head("full", 32'h8, 4);
      chk("full.ce", rom_ce, 0);
      chk("full.addr", rom_addr, 32'h18);
    end

    // One ready cycle while full: pop and push together.
    step();
    id_ready = 1'b1; #1;
    chk("pp.ce", rom_ce, 1);
    step();
    id_ready = 1'b0; #1;
    chk_head("pp.after", 32'hC, 4);
    chk("pp.addr", rom_addr, 32'h1C);
    chk("pp.ce_off", rom_ce, 0);

    // Drain in order while refetching.
    for (int i = 0; i < 6; i++) begin
      step();
      id_ready = 1'b1; #1;
      chk_head("drain", 32'hC + 32'(i) * 4, 4);
    end

    // Redirect to 0x100 with ID stalled.
    step();
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("rd1.ce", rom_ce, 0);
    step();
    redirect = 1'b0; #1;
    chk("rd1.count", count, 0);
    chk("rd1.valid", id_valid, 0);
    chk("rd1.pc", id_pc, 0);
    chk("rd1.addr", rom_addr, 32'h100);
    chk("rd1.ce1", rom_ce, 1);
    step(); #1; chk_head("rd1.h", 32'h100, 1);
    step(); #1; chk_head("rd1.h2", 32'h100, 2);
    step();
    // count = 3, ready=1 but the head is discarded by the redirect.
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk_head("rd2.pre", 32'h100, 3);
    chk("rd2.ce", rom_ce, 0);
    step();
    redirect = 1'b0; #1;
    chk("rd2.count", count, 0);
    chk("rd2.valid", id_valid, 0);
    chk("rd2.inst", id_inst, 0);
    chk("rd2.addr", rom_addr, 32'h200);
    chk("rd2.ce1", rom_ce, 1);
    step(); #1; chk_head("rd2.h", 32'h200, 1);

    // Back-to-back redirects: last one wins.
    step();
    redirect = 1'b1; redirect_pc = 32'h300; #1;
    step();
    redirect_pc = 32'h400; #1;
    chk("b2b.addr1", rom_addr, 32'h300);
    chk("b2b.count", count, 0);
    step();
    redirect = 1'b0; #1;
    chk("b2b.addr2", rom_addr, 32'h400);
    chk("b2b.ce", rom_ce, 1);
    step();

    // Random back-pressure across several pointer wraps.
    fetches = 1; issues = 0;
    exp_fetch = 32'h404; exp_issue = 32'h400;
    for (int i = 0; i < 40; i++) begin
      id_ready = 1'($urandom_range(0, 1)); #1;
      chk("rnd.count", count, 64'(fetches - issues));
      if (rom_ce) begin
        chk("rnd.fetch", rom_addr, exp_fetch);
        exp_fetch += 4; fetches++;
      end
      if (id_valid && id_ready) begin
        chk("rnd.issue", id_pc, exp_issue);
        chk("rnd.inst", id_inst, exp_issue + 32'h1000);
        exp_issue += 4; issues++;
      end
      step();
    end

    // Stall to full, then async reset between edges.
    id_ready = 1'b0;
    repeat (5) step();
    #1 chk("ar.full", count, 4);
    #1 rst = 1'b1;
    #1;
    chk("ar.count", count, 0);
    chk("ar.valid", id_valid, 0);
    chk("ar.pc", id_pc, 0);
    chk("ar.inst", id_inst, 0);
    chk("ar.ce", rom_ce, 0);
    chk("ar.addr", rom_addr, 0);
    step();
    rst = 1'b0; id_ready = 1'b1;
    step(); #1;
    chk("ar.ce1", rom_ce, 1);
    chk("ar.addr1", rom_addr, 0);
    step(); #1;
    chk_head("ar.h", 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
